// File: rtl/fp16_norm_pack_pkg.sv
// Shared widths, constants and FSM state encoding for the FP16 normalizer/packer.
package fp16_pkg;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int FP16_MAG_W   = 12;
    localparam int FP16_EXP_MAX = 30;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;
endpackage

// File: rtl/fp16_norm_pack_if.sv
// Operand/result handshake bundle; master drives operands, slave is the normalizer.
interface fp16_norm_pack_if import fp16_pkg::*; ();
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [FP16_EXP_W-1:0] in_exp;
    logic [FP16_MAG_W-1:0] in_mag;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_data;
    logic                  out_ovf;
    logic                  out_unf;
    logic                  out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mag, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mag, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf, out_inexact
    );
endinterface

// File: rtl/fp16_norm_pack_rshift_round.sv
// One-bit carry right shift of the magnitude; FP16_NORM_ROUND_EN adds ties-to-even rounding.
module fp16_rshift_round import fp16_pkg::*; (
    input  logic [FP16_MAG_W-1:0] mag_i,
    output logic [FP16_MAG_W-1:0] mag_o,
    output logic                  dropped_o
);
    logic [FP16_MAG_W-1:0] shifted;

    assign shifted   = mag_i >> 1;
    assign dropped_o = mag_i[0];

`ifdef FP16_NORM_ROUND_EN
    // A single dropped bit is always exactly half an ULP, so round up only to reach an even LSB.
    assign mag_o = (dropped_o && shifted[0]) ? shifted + 1'b1 : shifted;
`else
    assign mag_o = shifted;
`endif
endmodule

// File: rtl/fp16_norm_pack.sv
// Iterative FP16 post-adder normalizer and binary16 packer (one shift per cycle).
// Rounding on carry right-shifts is enabled by defining FP16_NORM_ROUND_EN.
module fp16_norm_pack import fp16_pkg::*; (
    input  logic               clk,
    input  logic               rst,
    fp16_norm_pack_if.slave    io
);
    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic [FP16_EXP_W-1:0] exp_q, exp_d;
    logic [FP16_MAG_W-1:0] mag_q, mag_d;
    logic                  inexact_q, inexact_d;
    logic [15:0]           data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  inex_out_q, inex_out_d;

    logic [FP16_MAG_W-1:0] rs_mag;
    logic                  rs_dropped;

    fp16_rshift_round u_rshift (
        .mag_i     (mag_q),
        .mag_o     (rs_mag),
        .dropped_o (rs_dropped)
    );

    assign io.in_ready    = (state_q == IDLE) && !rst;
    assign io.out_valid   = (state_q == OUT);
    assign io.out_data    = data_q;
    assign io.out_ovf     = ovf_q;
    assign io.out_unf     = unf_q;
    assign io.out_inexact = inex_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mag_q      <= '0;
            inexact_q  <= 1'b0;
            data_q     <= 16'h0000;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inex_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mag_q      <= mag_d;
            inexact_q  <= inexact_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inex_out_q <= inex_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mag_d      = mag_q;
        inexact_d  = inexact_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inex_out_d = inex_out_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    sign_d    = io.in_sign;
                    exp_d     = io.in_exp;
                    mag_d     = io.in_mag;
                    inexact_d = 1'b0;
                    state_d   = NORM;
                end
            end
            NORM: begin
                ovf_d      = 1'b0;
                unf_d      = 1'b0;
                inex_out_d = inexact_q;
                if (mag_q == '0) begin
                    // Exact cancellation always yields +0.
                    data_d  = 16'h0000;
                    state_d = OUT;
                end else if (mag_q[FP16_MAG_W-1]) begin
                    if (exp_q == FP16_EXP_W'(FP16_EXP_MAX)) begin
                        data_d  = {sign_q, FP16_POS_INF[14:0]};
                        ovf_d   = 1'b1;
                        state_d = OUT;
                    end else begin
                        mag_d     = rs_mag;
                        exp_d     = exp_q + 1'b1;
                        inexact_d = inexact_q | rs_dropped;
                    end
                end else if (mag_q[FP16_FRAC_W]) begin
                    data_d  = {sign_q, exp_q, mag_q[FP16_FRAC_W-1:0]};
                    state_d = OUT;
                end else if (exp_q == FP16_EXP_W'(1)) begin
                    data_d  = {sign_q, {FP16_EXP_W{1'b0}}, mag_q[FP16_FRAC_W-1:0]};
                    unf_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 1'b1;
                end
            end
            OUT: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp16_norm_pack.sv
// Directed self-checking bench for fp16_norm_pack (honours FP16_NORM_ROUND_EN when defined).
module tb_fp16_norm_pack;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    fp16_norm_pack_if io ();

    fp16_norm_pack dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    // Operands presented on an accepting edge must carry a legal exponent.
    always @(posedge clk) begin
        if (!rst && io.in_valid && io.in_ready) begin
            n_assert++;
            assert (io.in_exp >= 5'd1 && io.in_exp <= 5'd30)
            else begin
                n_fail++;
                $error("FAIL in_exp_legal observed=%0d expected=1..30", io.in_exp);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one operand, wait for the result, check latency/data/flags, then drain it.
    task automatic run_vec(input string name, input logic s, input logic [4:0] e,
                           input logic [11:0] m, input logic [15:0] x_data,
                           input logic x_ovf, input logic x_unf, input logic x_inex,
                           input int x_lat, input int hold);
        int n;
        check({name, "_in_ready"}, {31'd0, io.in_ready}, 32'd1);
        io.in_valid = 1'b1;
        io.in_sign  = s;
        io.in_exp   = e;
        io.in_mag   = m;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        n = 0;
        while (!io.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, x_lat);
        check({name, "_data"}, {16'd0, io.out_data}, {16'd0, x_data});
        check({name, "_flags"}, {29'd0, io.out_ovf, io.out_unf, io.out_inexact},
              {29'd0, x_ovf, x_unf, x_inex});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_data"}, {15'd0, io.out_valid, io.out_data}, {15'd0, 1'b1, x_data});
            check({name, "_hold_in_ready"}, {31'd0, io.in_ready}, 32'd0);
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check({name, "_drained"}, {31'd0, io.out_valid}, 32'd0);
        $display("vec %-10s s=%0d e=%0d m=%03h -> data=%04h ovf=%0d unf=%0d inx=%0d lat=%0d",
                 name, s, e, m, io.out_data, io.out_ovf, io.out_unf, io.out_inexact, n);
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_sign   = 1'b0;
        io.in_exp    = 5'd15;
        io.in_mag    = '0;
        io.out_ready = 1'b0;

        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", {31'd0, io.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("rst_out_data", {16'd0, io.out_data}, 32'd0);
        check("rst_flags", {29'd0, io.out_ovf, io.out_unf, io.out_inexact}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, io.in_ready}, 32'd1);

        run_vec("one",     1'b0, 5'd15, 12'h400, 16'h3C00, 1'b0, 1'b0, 1'b0, 1, 5);
        run_vec("two",     1'b0, 5'd15, 12'h800, 16'h4000, 1'b0, 1'b0, 1'b0, 2, 0);
        run_vec("lshift10",1'b0, 5'd15, 12'h001, 16'h1400, 1'b0, 1'b0, 1'b0, 11, 0);
        run_vec("zero",    1'b1, 5'd15, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0);
        run_vec("ovf",     1'b1, 5'd30, 12'h800, 16'hFC00, 1'b1, 1'b0, 1'b0, 1, 0);
        run_vec("subnorm", 1'b0, 5'd2,  12'h100, 16'h0200, 1'b0, 1'b1, 1'b0, 2, 0);
        run_vec("neg_norm",1'b1, 5'd20, 12'h5A5, 16'hD1A5, 1'b0, 1'b0, 1'b0, 1, 0);
        run_vec("lshift3", 1'b0, 5'd10, 12'h0C0, 16'h1E00, 1'b0, 1'b0, 1'b0, 4, 0);
        run_vec("tie_even",1'b0, 5'd15, 12'h801, 16'h4000, 1'b0, 1'b0, 1'b1, 2, 0);
`ifdef FP16_NORM_ROUND_EN
        run_vec("round_up",1'b0, 5'd15, 12'hFFF, 16'h4400, 1'b0, 1'b0, 1'b1, 3, 0);
`else
        run_vec("trunc",   1'b0, 5'd15, 12'hFFF, 16'h43FF, 1'b0, 1'b0, 1'b1, 2, 0);
`endif

        // Reset in the middle of a long normalization must discard it.
        io.in_valid = 1'b1;
        io.in_sign  = 1'b0;
        io.in_exp   = 5'd15;
        io.in_mag   = 12'h001;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready_low", {31'd0, io.in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, io.in_ready}, 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 14; i++) begin
                @(posedge clk); #1;
                if (io.out_valid) seen++;
            end
            check("midrst_no_output", seen, 0);
        end
        $display("reset mid-NORM: discarded, in_ready=%0d", io.in_ready);

        run_vec("after_rst",1'b0, 5'd15, 12'h400, 16'h3C00, 1'b0, 1'b0, 1'b0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
